// File: rtl/lenet_result_reader.sv
// Captures the LeNet accelerator's 10 class scores, finds the signed argmax, and optionally streams the scores.
// Define LENET_READER_STREAM_EN to enable the score stream (SCAN -> STREAM -> DONE); otherwise SCAN goes straight to DONE.
module lenet_result_reader #(
    parameter int BITWIDTH = 32,
    parameter int LATENCY  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [BITWIDTH-1:0] scores [10],
    output logic                busy,
    output logic                s_valid,
    input  logic                s_ready,
    output logic [BITWIDTH-1:0] s_data,
    output logic [3:0]          s_index,
    output logic                s_last,
    output logic                class_valid,
    output logic [3:0]          class_id,
    output logic [BITWIDTH-1:0] class_score
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_SCAN   = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int            CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(LATENCY - 1);
    localparam logic [3:0]    LAST_IDX  = 4'd9;

    logic [2:0]          state_q, state_d;
    logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [3:0]          k_q, k_d;
    logic [BITWIDTH-1:0] buf_q [10];
    logic [BITWIDTH-1:0] buf_d [10];
    logic [BITWIDTH-1:0] max_q, max_d;
    logic [3:0]          max_idx_q, max_idx_d;
    logic [3:0]          class_id_q, class_id_d;
    logic [BITWIDTH-1:0] class_score_q, class_score_d;
    logic [BITWIDTH-1:0] cand;
    logic                take;

    // The entry at k_q feeds both the comparator (SCAN) and the stream data (STREAM).
    assign cand = buf_q[k_q];
    assign take = (k_q == 4'd0) || ($signed(cand) > $signed(max_q));

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        k_d           = k_q;
        buf_d         = buf_q;
        max_d         = max_q;
        max_idx_d     = max_idx_q;
        class_id_d    = class_id_q;
        class_score_d = class_score_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    buf_d   = scores;
                    k_d     = '0;
                    state_d = ST_SCAN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_SCAN: begin
                if (take) begin
                    max_d     = cand;
                    max_idx_d = k_q;
                end
                if (k_q == LAST_IDX) begin
                    k_d = '0;
`ifdef LENET_READER_STREAM_EN
                    state_d = ST_STREAM;
`else
                    state_d       = ST_DONE;
                    class_id_d    = max_idx_d;
                    class_score_d = max_d;
`endif
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_STREAM: begin
`ifdef LENET_READER_STREAM_EN
                if (s_ready) begin
                    if (k_q == LAST_IDX) begin
                        state_d       = ST_DONE;
                        class_id_d    = max_idx_q;
                        class_score_d = max_q;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_buf
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    buf_q[gi] <= '0;
                end else begin
                    buf_q[gi] <= buf_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            k_q           <= '0;
            max_q         <= '0;
            max_idx_q     <= '0;
            class_id_q    <= '0;
            class_score_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            k_q           <= k_d;
            max_q         <= max_d;
            max_idx_q     <= max_idx_d;
            class_id_q    <= class_id_d;
            class_score_q <= class_score_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign class_valid = (state_q == ST_DONE);
    assign class_id    = class_id_q;
    assign class_score = class_score_q;

`ifdef LENET_READER_STREAM_EN
    assign s_valid = (state_q == ST_STREAM);
    assign s_data  = s_valid ? cand : '0;
    assign s_index = s_valid ? k_q : 4'd0;
    assign s_last  = s_valid && (k_q == LAST_IDX);
`else
    logic unused_s_ready;
    assign unused_s_ready = s_ready;
    assign s_valid = 1'b0;
    assign s_data  = '0;
    assign s_index = 4'd0;
    assign s_last  = 1'b0;
`endif
endmodule

// File: tb/tb_lenet_result_reader.sv
// Randomized scoreboard bench for lenet_result_reader: a plain argmax model predicts class results and stream beats.
`timescale 1ns/1ps
module tb_lenet_result_reader;
    localparam int BW  = 32;
    localparam int LAT = 4;
`ifdef LENET_READER_STREAM_EN
    localparam int STREAM_CYCLES = 10;
`else
    localparam int STREAM_CYCLES = 0;
`endif

    typedef logic [BW-1:0] vec_t [10];
    typedef struct { int id; logic [BW-1:0] score; int cyc; } exp_t;
    typedef struct { int idx; logic [BW-1:0] data; } sitem_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          s_ready = 1'b1;
    logic [BW-1:0] scores [10];
    logic          busy, s_valid, s_last, class_valid;
    logic [BW-1:0] s_data, class_score;
    logic [3:0]    s_index, class_id;

    int  n_tests = 0, n_fail = 0, cyc = 0, ready_mode = 0, stall_n = 0, stray = 0;
    bit  ignore_stream = 1'b0;
    exp_t   cq[$];
    sitem_t sq[$];

    lenet_result_reader #(.BITWIDTH(BW), .LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .scores(scores),
        .busy(busy), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_index(s_index), .s_last(s_last), .class_valid(class_valid),
        .class_id(class_id), .class_score(class_score)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Consumer ready: 0 = always ready, 1 = random, 2 = three-cycle stall at index 4.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: s_ready = 1'($urandom_range(0, 1));
            2: begin
                if (s_valid && s_index == 4'd4 && stall_n < 3) begin
                    s_ready = 1'b0;
                    stall_n++;
                end else begin
                    s_ready = 1'b1;
                end
            end
            default: s_ready = 1'b1;
        endcase
    end

    // Monitor: compares every handshake and class strobe against the scoreboard queues.
    logic [BW-1:0] prev_data;
    logic [3:0]    prev_idx;
    bit            prev_stall = 1'b0;
    exp_t          mon_e;
    sitem_t        mon_it;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (s_valid || s_last || s_index != 4'd0 || s_data != '0) stray++;
            if (prev_stall) begin
                check("stall_valid", s_valid, 1);
                check("stall_index", s_index, prev_idx);
                check("stall_data", s_data, prev_data);
            end
            prev_stall = s_valid && !s_ready;
            prev_idx   = s_index;
            prev_data  = s_data;
            if (s_valid && s_ready && !ignore_stream) begin
                if (sq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL stream_unexpected: got index %0d, required no beat", s_index);
                end else begin
                    mon_it = sq.pop_front();
                    check("s_index", s_index, mon_it.idx);
                    check("s_data", s_data, mon_it.data);
                    check("s_last", s_last, (mon_it.idx == 9) ? 1 : 0);
                end
            end
            if (class_valid) begin
                if (cq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL class_unexpected: got class_valid=1 (id %0d), required no pulse", class_id);
                end else begin
                    mon_e = cq.pop_front();
                    check("class_id", class_id, mon_e.id);
                    check("class_score", class_score, mon_e.score);
                    if (mon_e.cyc >= 0) check("class_valid_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic run_txn(input vec_t v, input int mode, input bit repulse, input bit start_in_done, input int tag);
        exp_t e;
        int   best;
        bit   got;
        vec_t junk;
        ready_mode = mode;
        stall_n    = 0;
        @(posedge clk); #1;
        scores = v;
        best = 0;
        for (int i = 1; i < 10; i++) if ($signed(v[i]) > $signed(v[best])) best = i;
        e.id    = best;
        e.score = v[best];
        if (STREAM_CYCLES != 0 && mode == 1) e.cyc = -1;
        else e.cyc = cyc + LAT + 11 + STREAM_CYCLES + ((STREAM_CYCLES != 0 && mode == 2) ? 3 : 0);
        cq.push_back(e);
`ifdef LENET_READER_STREAM_EN
        for (int i = 0; i < 10; i++) sq.push_back('{idx: i, data: v[i]});
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) junk[i] = $urandom;
        scores = junk;
        if (repulse) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (class_valid) begin got = 1'b1; break; end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL class_timeout: got no class_valid in 400 cycles, required one (txn %0d)", tag);
            if (cq.size() != 0) void'(cq.pop_front());
        end
        if (got && start_in_done) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("start_in_done_ignored", busy, 0);
        end
        $display("[TB] txn %0d: mode=%0d repulse=%0d expected id=%0d score=0x%0h", tag, mode, repulse, e.id, e.score);
        repeat (2) @(posedge clk);
    endtask

    task automatic run_reset();
        vec_t v;
        bit   found;
        ignore_stream = 1'b1;
        ready_mode    = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) v[i] = $urandom;
        scores = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef LENET_READER_STREAM_EN
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_valid && s_index == 4'd6) begin found = 1'b1; break; end
        end
        check("reach_k6", found, 1);
`else
        repeat (LAT + 5) @(negedge clk);
`endif
        check("busy_before_reset", busy, 1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_s_valid", s_valid, 0);
        check("rst_s_last", s_last, 0);
        check("rst_s_index", s_index, 0);
        check("rst_s_data", s_data, 0);
        check("rst_class_valid", class_valid, 0);
        check("rst_class_id", class_id, 0);
        check("rst_class_score", class_score, 0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        ignore_stream = 1'b0;
        repeat (30) @(posedge clk);
        check("idle_after_reset", busy, 0);
        $display("[TB] txn reset: abandoned mid-operation");
    endtask

    initial begin
        vec_t v;
        int   t1 [10] = '{3, -5, 17, 2, 17, 0, 1, 9, -1, 4};
        for (int i = 0; i < 10; i++) scores[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("init_busy", busy, 0);
        check("init_s_valid", s_valid, 0);
        check("init_class_valid", class_valid, 0);
        check("init_class_id", class_id, 0);
        check("init_class_score", class_score, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) v[i] = t1[i];
        run_txn(v, 0, 1'b0, 1'b0, 1);
        check("t1_class_id_const", class_id, 2);
        check("t1_class_score_const", class_score, 17);
        run_reset();

        for (int i = 0; i < 10; i++) v[i] = 32'hFFFFFF9C;
        run_txn(v, 0, 1'b0, 1'b1, 2);
        check("t2_class_id_const", class_id, 0);
        check("t2_class_score_const", class_score, 32'hFFFFFF9C);

        for (int i = 0; i < 10; i++) v[i] = $urandom;
        run_txn(v, 2, 1'b0, 1'b0, 3);
        for (int i = 0; i < 10; i++) v[i] = 32'($urandom_range(0, 8)) - 32'd4;
        run_txn(v, 0, 1'b1, 1'b0, 4);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 10; i++)
                v[i] = (t % 2 == 1) ? $urandom : 32'($urandom_range(0, 8)) - 32'd4;
            run_txn(v, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5 + t);
        end

        repeat (20) @(posedge clk);
        check("class_queue_empty", cq.size(), 0);
        check("stream_queue_empty", sq.size(), 0);
`ifndef LENET_READER_STREAM_EN
        check("stream_tied_zero", stray, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
